bigdemux_bank: RTL and testbench
================================

BIGDEMUX_BANK -- requirements
Module: bigdemux_bank

Interface
REQ-001 Parameter LANES, default 64, number of output lanes (width of each write word).
REQ-002 Parameter SLOTS, default 32, bit positions per lane; power of two, >= 2; SELW = log2(SLOTS).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 wr_valid  input  1  write request qualifier.
REQ-006 wr_ready  output  1  block can accept a write this cycle.
REQ-007 wr_sel  input  SELW  target bit position (column) for the write.
REQ-008 wr_data  input  LANES  one bit per lane to store at column wr_sel.
REQ-009 clr_req  input  1  request a full-bank sequential clear.
REQ-010 busy  output  1  high while a clear sweep is in progress.
REQ-011 clr_done  output  1  one-cycle pulse when a clear sweep completes.
REQ-012 out  output  [LANES-1:0][SLOTS-1:0]  stored bank; lane i, bit j = out[i][j]; drives the existing 64x32 select mux input directly.
REQ-013 written  output  SLOTS  per-column flag; column written since last clear or reset.

Function
REQ-014 Two states only: IDLE and CLEAR; state register, column counter, out, written, clr_done are flops.
REQ-015 wr_ready shall equal (state == IDLE), combinational from state only; no dependence on wr_valid or clr_req.
REQ-016 Write accepted on a rising edge where wr_valid && wr_ready.
REQ-017 Accepted write: for every lane i, out[i][wr_sel] <= wr_data[i]; written[wr_sel] <= 1; all other columns unchanged.
REQ-018 Write latency: new value visible on out exactly one cycle after the accepting edge.
REQ-019 Back-to-back writes accepted every cycle in IDLE; repeated writes to one column overwrite; last accepted wins.
REQ-020 wr_valid while wr_ready low: ignored, no state change, no buffering; requester must hold and retry.
REQ-021 IDLE -> CLEAR on an edge with clr_req high; column counter loaded with 0 on that edge; busy high from next cycle.
REQ-022 clr_req and an accepted write on the same IDLE edge: write performed on that edge, then the sweep starts and erases it in turn.
REQ-023 In CLEAR, each edge: out[i][cnt] <= 0 for all lanes, written[cnt] <= 0, cnt <= cnt + 1.
REQ-024 Sweep order column 0 to SLOTS-1, one column per cycle; sweep lasts exactly SLOTS cycles.
REQ-025 On the edge clearing column SLOTS-1: state <= IDLE, counter <= 0, clr_done <= 1 for one cycle.
REQ-026 clr_done low in every other cycle; busy = (state == CLEAR).
REQ-027 clr_req while in CLEAR ignored (no restart, no queued second sweep); clr_req held high at sweep end starts a new sweep on the next IDLE edge.
REQ-028 Counter is SELW bits; no wrap beyond SLOTS-1 is observable; counter value irrelevant in IDLE.
REQ-029 Columns not yet reached by an active sweep keep their contents until cleared.

Reset
REQ-030 reset_n low asynchronously forces: state IDLE, counter 0, out all zero, written 0, clr_done 0; thus wr_ready 1 and busy 0 while in reset.
REQ-031 Reset asserted mid-sweep aborts the sweep immediately; no clr_done pulse is produced.
REQ-032 First write may be accepted on the first rising edge after reset_n deasserts.

Verification
REQ-033 Reset, then write wr_sel=i, wr_data=64'h1<<i for i=0..31, one per cycle -> next cycle out[i][i]=1 only; written=32'hFFFF_FFFF after 32 writes.
REQ-034 Write wr_sel=5, wr_data=64'hFFFF_0000_FFFF_0000, then wr_sel=5, data=0 next cycle -> out[i][5] follows each word one cycle later; other columns unchanged.
REQ-035 Bank full of ones, pulse clr_req one cycle -> busy high for 32 cycles, column k zero k+1 cycles after sweep start, clr_done single pulse at end, written=0, wr_ready back to 1.
REQ-036 Hold wr_valid with wr_sel=3 during CLEAR -> no write until IDLE; write lands the cycle after wr_ready returns.
REQ-037 clr_req and write (wr_sel=31, data all ones) on same edge -> column 31 set one cycle, then cleared at sweep end; written[31]=0 after clr_done.
REQ-038 Drop reset_n at sweep column 10 -> out all zero, busy 0 immediately, no clr_done pulse.

Source files
------------

// File: rtl/bigdemux_bank.sv
// Bit-column write bank: each write stores one bit per lane into a selected column,
// and a clear request sweeps the bank to zero one column per cycle.
module bigdemux_bank #(
  parameter int LANES = 64,
  parameter int SLOTS = 32
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [$clog2(SLOTS)-1:0]      wr_sel,
  input  logic [LANES-1:0]              wr_data,
  input  logic                          clr_req,
  output logic                          busy,
  output logic                          clr_done,
  output logic [LANES-1:0][SLOTS-1:0]   out,
  output logic [SLOTS-1:0]              written
);

  localparam int SELW = $clog2(SLOTS);
  localparam logic [SELW-1:0] LAST_COL = SELW'(SLOTS - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state_reg;
  logic [SELW-1:0]  cnt_reg;
  logic [SLOTS-1:0] written_reg;
  logic             clr_done_reg;

  assign wr_ready = (state_reg == IDLE);
  assign busy     = (state_reg == CLEAR);
  assign clr_done = clr_done_reg;
  assign written  = written_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      written_reg  <= '0;
      clr_done_reg <= 1'b0;
    end else begin
      clr_done_reg <= 1'b0;
      if (state_reg == IDLE) begin
        if (wr_valid) begin
          written_reg[wr_sel] <= 1'b1;
        end
        // A write on the same edge still lands; the sweep erases it later.
        if (clr_req) begin
          state_reg <= CLEAR;
          cnt_reg   <= '0;
        end
      end else begin
        written_reg[cnt_reg] <= 1'b0;
        cnt_reg              <= cnt_reg + 1'b1;
        if (cnt_reg == LAST_COL) begin
          state_reg    <= IDLE;
          cnt_reg      <= '0;
          clr_done_reg <= 1'b1;
        end
      end
    end
  end

  // Each lane owns its own row of column bits.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [SLOTS-1:0] lane_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          lane_reg <= '0;
        end else if (state_reg == CLEAR) begin
          lane_reg[cnt_reg] <= 1'b0;
        end else if (wr_valid) begin
          lane_reg[wr_sel] <= wr_data[gi];
        end
      end

      assign out[gi] = lane_reg;
    end
  endgenerate

endmodule

// File: tb/tb_bigdemux_bank.sv
// Directed bench for bigdemux_bank: writes, overwrite, full sweep, blocked writes,
// write+clear collision and reset abort, each checked against hand-computed values.
module tb_bigdemux_bank;

  logic              clk;
  logic              reset_n;
  logic              wr_valid;
  logic              wr_ready;
  logic [4:0]        wr_sel;
  logic [63:0]       wr_data;
  logic              clr_req;
  logic              busy;
  logic              clr_done;
  logic [63:0][31:0] bank;
  logic [31:0]       written;

  int errors = 0;
  int checks = 0;

  localparam logic [63:0] ONES = {64{1'b1}};
  localparam logic [63:0] PAT  = 64'hFFFF_0000_FFFF_0000;
  localparam logic [63:0] PATA = 64'h1234_5678_9ABC_DEF0;

  bigdemux_bank dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_done (clr_done),
    .out      (bank),
    .written  (written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] col(input int j);
    logic [63:0] c;
    for (int i = 0; i < 64; i++) c[i] = bank[i][j];
    return c;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    wr_valid = 1'b0;
    wr_sel   = '0;
    wr_data  = '0;
    clr_req  = 1'b0;
    tick();
    tick();
    chk("rst_ready", {63'd0, wr_ready}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, clr_done}, 64'd0);
    chk("rst_written", {32'd0, written}, 64'd0);
    chk("rst_out_zero", {63'd0, (bank === '0)}, 64'd1);
    reset_n = 1'b1;

    // Diagonal: column i gets only lane i set.
    for (int i = 0; i < 32; i++) begin
      wr_valid = 1'b1;
      wr_sel   = 5'(i);
      wr_data  = 64'h1 << i;
      tick();
      chk($sformatf("diag_col%0d", i), col(i), 64'h1 << i);
    end
    wr_valid = 1'b0;
    chk("diag_written", {32'd0, written}, 64'h0000_0000_FFFF_FFFF);
    for (int j = 0; j < 32; j++) chk($sformatf("diag_keep%0d", j), col(j), 64'h1 << j);

    // Overwrite column 5 twice.
    wr_valid = 1'b1; wr_sel = 5'd5; wr_data = PAT;
    tick();
    chk("ow_col5_a", col(5), PAT);
    chk("ow_col4", col(4), 64'h1 << 4);
    wr_data = 64'd0;
    tick();
    chk("ow_col5_b", col(5), 64'd0);
    chk("ow_col6", col(6), 64'h1 << 6);
    wr_valid = 1'b0;
    tick();
    chk("ow_idle_hold", col(5), 64'd0);

    // Fill with ones, then full sweep.
    for (int j = 0; j < 32; j++) begin
      wr_valid = 1'b1; wr_sel = 5'(j); wr_data = ONES;
      tick();
    end
    wr_valid = 1'b0;
    chk("fill_all_ones", {63'd0, (&bank)}, 64'd1);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("sw_busy_start", {63'd0, busy}, 64'd1);
    chk("sw_ready_low", {63'd0, wr_ready}, 64'd0);
    for (int k = 0; k < 32; k++) begin
      tick();
      chk($sformatf("sw_col%0d", k), col(k), 64'd0);
      if (k < 31) chk($sformatf("sw_next%0d", k + 1), col(k + 1), ONES);
      chk($sformatf("sw_busy%0d", k), {63'd0, busy}, (k < 31) ? 64'd1 : 64'd0);
      chk($sformatf("sw_done%0d", k), {63'd0, clr_done}, (k == 31) ? 64'd1 : 64'd0);
    end
    chk("sw_written", {32'd0, written}, 64'd0);
    chk("sw_ready_back", {63'd0, wr_ready}, 64'd1);
    tick();
    chk("sw_done_drop", {63'd0, clr_done}, 64'd0);

    // Write held during a sweep waits for IDLE.
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    wr_valid = 1'b1; wr_sel = 5'd3; wr_data = PATA;
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk($sformatf("hold_col3_%0d", k), col(3), 64'd0);
    end
    chk("hold_ready", {63'd0, wr_ready}, 64'd1);
    chk("hold_written0", {32'd0, written}, 64'd0);
    tick();
    wr_valid = 1'b0;
    chk("hold_land", col(3), PATA);
    chk("hold_written", {32'd0, written}, 64'h8);

    // Write and clear on the same edge.
    wr_valid = 1'b1; wr_sel = 5'd31; wr_data = ONES; clr_req = 1'b1;
    tick();
    wr_valid = 1'b0; clr_req = 1'b0;
    chk("col_c31_set", col(31), ONES);
    chk("col_written", {32'd0, written}, 64'h8000_0008);
    chk("col_busy", {63'd0, busy}, 64'd1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("col_c3_kept%0d", k), col(3), PATA);
    end
    tick();
    chk("col_c3_cleared", col(3), 64'd0);
    for (int k = 5; k <= 31; k++) tick();
    chk("col_c31_before_end", col(31), ONES);
    chk("col_done_early", {63'd0, clr_done}, 64'd0);
    tick();
    chk("col_c31_cleared", col(31), 64'd0);
    chk("col_done", {63'd0, clr_done}, 64'd1);
    chk("col_written_end", {32'd0, written}, 64'd0);

    // Reset mid-sweep.
    wr_valid = 1'b1; wr_sel = 5'd20; wr_data = ONES;
    tick();
    wr_valid = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int k = 1; k <= 10; k++) tick();
    chk("abort_c20_pre", col(20), ONES);
    chk("abort_busy_pre", {63'd0, busy}, 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_out_zero", {63'd0, (bank === '0)}, 64'd1);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_ready", {63'd0, wr_ready}, 64'd1);
    chk("abort_written", {32'd0, written}, 64'd0);
    tick();
    chk("abort_done_rst", {63'd0, clr_done}, 64'd0);
    reset_n = 1'b1;
    wr_valid = 1'b1; wr_sel = 5'd7; wr_data = 64'h5;
    tick();
    wr_valid = 1'b0;
    chk("abort_done_after", {63'd0, clr_done}, 64'd0);
    chk("post_rst_write", col(7), 64'h5);
    chk("post_rst_busy", {63'd0, busy}, 64'd0);
    tick();
    chk("post_rst_done", {63'd0, clr_done}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
